// File: rtl/pt2272_pkg.sv
// Shared types, pulse-width thresholds and classification helpers for the
// PT2272-style decoder.
package pt2272_pkg;

    typedef enum logic [1:0] {T0, T1, TF, TINV} trit_t;
    typedef enum logic [1:0] {PC_S, PC_L, PC_BAD} pclass_t;
    typedef enum logic [2:0] {HUNT, WAIT_HIGH, MEAS_HIGH, MEAS_LOW, CHECK} state_t;

    localparam logic [10:0] W_SHORT_MIN = 11'd2;
    localparam logic [10:0] W_LONG_MIN  = 11'd8;
    localparam logic [10:0] W_MAX       = 11'd20;

    function automatic pclass_t classify_high(input logic [10:0] w);
        if (w >= W_SHORT_MIN && w < W_LONG_MIN)
            return PC_S;
        else if (w >= W_LONG_MIN && w < W_MAX)
            return PC_L;
        else
            return PC_BAD;
    endfunction

    function automatic logic is_data_gap(input logic [10:0] w);
        return (w >= W_SHORT_MIN && w < W_MAX);
    endfunction

    function automatic trit_t decode_pair(input pclass_t a, input pclass_t b);
        if (a == PC_S && b == PC_S) return T0;
        if (a == PC_L && b == PC_L) return T1;
        if (a == PC_S && b == PC_L) return TF;
        return TINV;
    endfunction

endpackage

// File: rtl/pt2272_pulse_meter.sv
// Input synchroniser, edge detector and alpha-unit width counter for the
// serial line; width_alpha is the elapsed time of the current level.
module pt2272_pulse_meter #(
    parameter int ALPHA_CLKS = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic        rise,
    output logic        fall,
    output logic [10:0] width_alpha,
    output logic        level
);
    localparam int PW = (ALPHA_CLKS > 2) ? $clog2(ALPHA_CLKS) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(ALPHA_CLKS - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);

    logic          s1, s2, s3;
    logic [PW-1:0] pre;
    logic [10:0]   wid;

    // The edge cycle is counted as the first cycle of the new level, so the
    // captured width at the next edge is floor(cycles / ALPHA_CLKS).
    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            pre <= '0;
            wid <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
            if (s2 ^ s3) begin
                pre <= PRE_ONE;
                wid <= '0;
            end else if (pre == PRE_TOP) begin
                pre <= '0;
                if (wid != 11'h7FF)
                    wid <= wid + 11'd1;
            end else begin
                pre <= pre + PRE_ONE;
            end
        end
    end

    assign rise        = s2 & ~s3;
    assign fall        = ~s2 & s3;
    assign level       = s2;
    assign width_alpha = wid;

endmodule

// File: rtl/pt2272_decoder.sv
// PT2272-style latch decoder: rebuilds 8 address trits and 4 data bits from a
// PT2262 stream, checks the address and latches data after repeated frames.
module pt2272_decoder
    import pt2272_pkg::*;
#(
    parameter int ALPHA_CLKS = 250,
    parameter int REQ_FRAMES = 2,
    parameter int SYNC_MIN   = 64,
    parameter int IDLE_MAX   = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic [7:0] addr_val,
    input  logic [7:0] addr_f,
    output logic [3:0] dout,
    output logic       vt,
    output logic       frame_ok,
    output logic       frame_err
);
    localparam int CW = $clog2(REQ_FRAMES + 1);
    localparam logic [CW-1:0] REQ_C  = CW'(REQ_FRAMES);
    localparam logic [10:0]   SYNC_W = 11'(SYNC_MIN);
    localparam logic [10:0]   IDLE_W = 11'(IDLE_MAX);

    logic        rise, fall, level;
    logic [10:0] width;

    pt2272_pulse_meter #(.ALPHA_CLKS(ALPHA_CLKS)) u_meter (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .rise       (rise),
        .fall       (fall),
        .width_alpha(width),
        .level      (level)
    );

    state_t         state, state_nxt;
    logic [4:0]     pcnt, pcnt_nxt;
    logic           first_l, first_l_nxt;
    trit_t [11:0]   trits, trits_nxt;
    logic [3:0]     cand, data;
    logic [CW-1:0]  mcnt, cnt_nxt;
    logic           err, addr_ok, low_steady, idle;
    pclass_t        pc;
    trit_t          tr;

    // Low level that is not the cycle of a falling edge (width then still
    // belongs to the preceding high pulse).
    assign low_steady = ~level & ~fall;
    assign idle       = low_steady && (width >= IDLE_W);

    always_comb begin
        state_nxt   = state;
        pcnt_nxt    = pcnt;
        first_l_nxt = first_l;
        trits_nxt   = trits;
        err         = 1'b0;
        pc          = classify_high(width);
        tr          = decode_pair(first_l ? PC_L : PC_S, pc);
        case (state)
            HUNT: begin
                if (low_steady && width >= SYNC_W)
                    state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rise) begin
                    state_nxt = MEAS_HIGH;
                    pcnt_nxt  = '0;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    state_nxt = MEAS_LOW;
                    pcnt_nxt  = pcnt + 5'd1;
                    if (pc == PC_BAD)
                        err = 1'b1;
                    else if (pcnt == 5'd24)
                        err = (pc != PC_S);
                    else if (!pcnt[0])
                        first_l_nxt = (pc == PC_L);
                    else if (tr == TINV || (pcnt >= 5'd16 && tr == TF))
                        err = 1'b1;
                    else
                        trits_nxt[pcnt[4:1]] = tr;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    if (pcnt == 5'd25 || !is_data_gap(width))
                        err = 1'b1;
                    else
                        state_nxt = MEAS_HIGH;
                end else if (low_steady && width == SYNC_W) begin
                    if (pcnt == 5'd25)
                        state_nxt = CHECK;
                    else
                        err = 1'b1;
                end
            end
            CHECK:   state_nxt = WAIT_HIGH;
            default: state_nxt = HUNT;
        endcase
        if (err)
            state_nxt = HUNT;
    end

    always_comb begin
        addr_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (trits[i] != (addr_f[i] ? TF : (addr_val[i] ? T1 : T0)))
                addr_ok = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            data[i] = (trits[8+i] == T1);
        if (mcnt != '0 && data == cand)
            cnt_nxt = (mcnt == REQ_C) ? mcnt : mcnt + CW'(1);
        else
            cnt_nxt = CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            pcnt      <= '0;
            first_l   <= 1'b0;
            trits     <= {12{T0}};
            cand      <= '0;
            mcnt      <= '0;
            dout      <= '0;
            vt        <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pcnt      <= pcnt_nxt;
            first_l   <= first_l_nxt;
            trits     <= trits_nxt;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (idle) begin
                vt   <= 1'b0;
                mcnt <= '0;
            end
            if (err) begin
                frame_err <= 1'b1;
                vt        <= 1'b0;
                mcnt      <= '0;
            end else if (state == CHECK) begin
                if (addr_ok) begin
                    frame_ok <= 1'b1;
                    cand     <= data;
                    mcnt     <= cnt_nxt;
                    if (cnt_nxt == REQ_C) begin
                        dout <= data;
                        vt   <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                    vt        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pt2272_decoder.sv
// Directed bench: drives PT2262-encoded frames (alpha shortened to 4 clocks)
// and checks pulse counts, vt and dout after each frame.
module tb_pt2272_decoder;
    localparam int A = 4;

    logic       clk = 1'b0;
    logic       reset, din;
    logic [7:0] addr_val, addr_f;
    logic [3:0] dout;
    logic       vt, frame_ok, frame_err;

    int total = 0, bad = 0;
    int ok_cnt = 0, err_cnt = 0, err0;

    always #5 clk = ~clk;

    pt2272_decoder #(
        .ALPHA_CLKS(A), .REQ_FRAMES(2), .SYNC_MIN(64), .IDLE_MAX(1024)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .addr_val (addr_val),
        .addr_f   (addr_f),
        .dout     (dout),
        .vt       (vt),
        .frame_ok (frame_ok),
        .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (frame_ok)  ok_cnt  <= ok_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task level(input logic v, input int n);
        din = v;
        repeat (n * A) @(negedge clk);
    endtask

    task pulse(input bit l);
        if (l) begin level(1'b1, 12); level(1'b0, 4);  end
        else   begin level(1'b1, 4);  level(1'b0, 12); end
    endtask

    // trit codes: 0, 1, 2 = F, 3 = illegal LS pair
    task send_trit(input logic [1:0] t);
        case (t)
            2'd0: begin pulse(1'b0); pulse(1'b0); end
            2'd1: begin pulse(1'b1); pulse(1'b1); end
            2'd2: begin pulse(1'b0); pulse(1'b1); end
            default: begin pulse(1'b1); pulse(1'b0); end
        endcase
    endtask

    task send_frame(input logic [7:0][1:0] at, input logic [3:0] d, input int rst_at);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            send_trit(at[i]);
        end
        for (int i = 0; i < 4; i++)
            send_trit({1'b0, d[i]});
        level(1'b1, 4);
        level(1'b0, 124);
    endtask

    function automatic logic [7:0][1:0] mk_addr(input logic [7:0] v);
        logic [7:0][1:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = {1'b0, v[i]};
        return r;
    endfunction

    task frame_chk(input string tag, input logic [7:0][1:0] at, input logic [3:0] d,
                   input int rst_at, input int e_ok, input int e_err,
                   input int e_vt, input int e_dout);
        int ok_s, err_s;
        ok_s  = ok_cnt;
        err_s = err_cnt;
        send_frame(at, d, rst_at);
        chk({tag, ".ok"},   ok_cnt - ok_s,   e_ok);
        chk({tag, ".err"},  err_cnt - err_s, e_err);
        chk({tag, ".vt"},   32'(vt),         e_vt);
        chk({tag, ".dout"}, 32'(dout),       e_dout);
    endtask

    logic [7:0][1:0] base, fa0, one0, ls3;

    initial begin
        reset    = 1'b1;
        din      = 1'b0;
        addr_val = 8'h5A;
        addr_f   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.dout",      32'(dout),      0);
        chk("rst.vt",        32'(vt),        0);
        chk("rst.frame_ok",  32'(frame_ok),  0);
        chk("rst.frame_err", 32'(frame_err), 0);

        base = mk_addr(8'h5A);
        fa0  = base; fa0[0]  = 2'd2;
        one0 = base; one0[0] = 2'd1;
        ls3  = base; ls3[3]  = 2'd3;

        level(1'b0, 128);
        frame_chk("f1_a",  base, 4'hA, -1, 1, 0, 0, 0);
        frame_chk("f2_a",  base, 4'hA, -1, 1, 0, 1, 4'hA);
        frame_chk("f3_5",  base, 4'h5, -1, 1, 0, 1, 4'hA);
        frame_chk("f4_5",  base, 4'h5, -1, 1, 0, 1, 4'h5);

        addr_f = 8'h01;
        frame_chk("f5_fa0",  fa0,  4'h3, -1, 1, 0, 1, 4'h5);
        frame_chk("f6_fa0",  fa0,  4'h3, -1, 1, 0, 1, 4'h3);
        frame_chk("f7_one0", one0, 4'h3, -1, 0, 1, 0, 4'h3);

        addr_f = 8'h00;
        frame_chk("f8_a",  base, 4'hA, -1, 1, 0, 0, 4'h3);
        frame_chk("f9_a",  base, 4'hA, -1, 1, 0, 1, 4'hA);
        frame_chk("f10_ls", ls3, 4'hA, -1, 0, 1, 0, 4'hA);
        frame_chk("f11_a", base, 4'hA, -1, 1, 0, 0, 4'hA);
        frame_chk("f12_a", base, 4'hA, -1, 1, 0, 1, 4'hA);

        err0 = err_cnt;
        level(1'b0, 880);
        chk("idle_pre.vt", 32'(vt), 1);
        level(1'b0, 40);
        chk("idle.vt",   32'(vt),   0);
        chk("idle.dout", 32'(dout), 4'hA);
        chk("idle.err",  err_cnt - err0, 0);

        frame_chk("f13_5",   base, 4'h5, -1, 1, 0, 0, 4'hA);
        frame_chk("f14_5",   base, 4'h5, -1, 1, 0, 1, 4'h5);
        frame_chk("f15_rst", base, 4'h5,  5, 0, 0, 0, 0);
        frame_chk("f16_5",   base, 4'h5, -1, 1, 0, 0, 0);
        frame_chk("f17_5",   base, 4'h5, -1, 1, 0, 1, 4'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
